// File: rtl/div_result_bcd.sv
// Result stage of the 8-bit divider: captures one quotient/remainder pair and converts
// both to packed BCD with a bit-serial double-dabble engine behind a valid/ready interface.
module div_result_bcd #(
    parameter int W   = 8,
    parameter int DIG = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [W-1:0]     i_quo,
    input  logic [W-1:0]     i_rem,
    input  logic             i_div_zero,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [4*DIG-1:0] o_quo_bcd,
    output logic [4*DIG-1:0] o_rem_bcd,
    output logic             o_out_err
);

    localparam int              CW   = $clog2(W + 1);
    localparam logic [CW-1:0]   LAST = CW'(W - 1);
    localparam int              BW   = 4 * DIG;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_quoBin;
    logic [W-1:0]    r_remBin;
    logic [BW-1:0]   r_quoBcd;
    logic [BW-1:0]   r_remBcd;
    logic [CW-1:0]   r_cnt;
    logic            r_err;

    // One double-dabble step: correct every digit >=5 by +3, then shift {bcd,bin} left.
    function automatic logic [BW+W-1:0] convStep(input logic [BW-1:0] bcd,
                                                 input logic [W-1:0]  bin);
        logic [BW-1:0]   adj;
        logic [BW+W-1:0] cat;
        adj = bcd;
        for (int d = 0; d < DIG; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
        cat = {adj, bin};
        return cat << 1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_in_valid) begin
                    w_next = i_div_zero ? DONE : CONV;
                end
            end
            CONV: begin
                if (r_cnt == LAST) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (i_out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Divide-by-zero skips conversion, so the cleared accumulators become the zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quoBin <= '0;
            r_remBin <= '0;
            r_quoBcd <= '0;
            r_remBcd <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_quoBin <= i_quo;
                        r_remBin <= i_rem;
                        r_quoBcd <= '0;
                        r_remBcd <= '0;
                        r_cnt    <= '0;
                        r_err    <= i_div_zero;
                    end
                end
                CONV: begin
                    {r_quoBcd, r_quoBin} <= convStep(r_quoBcd, r_quoBin);
                    {r_remBcd, r_remBin} <= convStep(r_remBcd, r_remBin);
                    r_cnt                <= r_cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign o_in_ready  = (r_state == IDLE);
    assign o_out_valid = (r_state == DONE);
    assign o_quo_bcd   = r_quoBcd;
    assign o_rem_bcd   = r_remBcd;
    assign o_out_err   = r_err;

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed bench for div_result_bcd: latency, hold, divide-by-zero, mid-conversion reset,
// back-to-back throughput and an exhaustive sweep against a decimal reference.
module tb_div_result_bcd;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [7:0]  quo;
    logic [7:0]  rem;
    logic        divZero;
    logic        outValid;
    logic        outReady;
    logic [11:0] quoBcd;
    logic [11:0] remBcd;
    logic        outErr;

    int checks;
    int errors;

    div_result_bcd #(.W(8), .DIG(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_in_valid (inValid),
        .o_in_ready (inReady),
        .i_quo      (quo),
        .i_rem      (rem),
        .i_div_zero (divZero),
        .o_out_valid(outValid),
        .i_out_ready(outReady),
        .o_quo_bcd  (quoBcd),
        .o_rem_bcd  (remBcd),
        .o_out_err  (outErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference conversion by decimal arithmetic
    function automatic logic [11:0] toBcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Presents one pair for exactly one rising edge; returns #1 after the accept edge.
    task automatic sendPair(input int q, input int r, input logic dz);
        @(negedge clk);
        quo     = 8'(q);
        rem     = 8'(r);
        divZero = dz;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid; -1 on timeout.
    task automatic waitValid(output int lat);
        lat = 0;
        if (outValid === 1'b1) return;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (outValid === 1'b1) begin
                lat = i;
                return;
            end
        end
        lat = -1;
    endtask

    task automatic handshake();
        @(negedge clk);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (inReady !== 1'b1 || outValid !== 1'b0 || quoBcd !== 12'h000 ||
            remBcd !== 12'h000 || outErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset: rdy=%b vld=%b q=%h r=%h err=%b, want 1 0 000 000 0",
                     inReady, outValid, quoBcd, remBcd, outErr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_max();
        int lat;
        sendPair(255, 0, 1'b0);
        waitValid(lat);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("[TB] FAIL max_latency: got %0d want 8", lat);
        end
        checks++;
        if (quoBcd !== 12'h255 || remBcd !== 12'h000 || outErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL max_value: q=%h r=%h err=%b want 255 000 0", quoBcd, remBcd, outErr);
        end
        handshake();
        checks++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL max_release: vld=%b rdy=%b want 0 1", outValid, inReady);
        end
    endtask

    // Leaves the 100/7 result waiting in DONE for test_hold.
    task automatic test_small();
        int lat;
        sendPair(14, 2, 1'b0);
        checks++;
        if (inReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL small_busy: in_ready=%b want 0", inReady);
        end
        waitValid(lat);
        checks++;
        if (lat !== 8 || quoBcd !== 12'h014 || remBcd !== 12'h002 || outErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL small_value: lat=%0d q=%h r=%h err=%b want 8 014 002 0",
                     lat, quoBcd, remBcd, outErr);
        end
        checks++;
        if (inReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL small_done_ready: in_ready=%b want 0", inReady);
        end
    endtask

    task automatic test_hold();
        bit stable;
        bit quiet;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            inValid = (i == 2);
            quo     = 8'h11;
            rem     = 8'h22;
            @(posedge clk);
            #1;
            inValid = 1'b0;
            if (outValid !== 1'b1 || inReady !== 1'b0 || quoBcd !== 12'h014 ||
                remBcd !== 12'h002 || outErr !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("[TB] FAIL hold_stable: vld=%b rdy=%b q=%h r=%h want 1 0 014 002",
                     outValid, inReady, quoBcd, remBcd);
        end
        handshake();
        quiet = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (outValid !== 1'b0 || inReady !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("[TB] FAIL hold_ignored_input: vld=%b rdy=%b want 0 1", outValid, inReady);
        end
    endtask

    // A zero divisor goes straight to DONE, so out_valid is already up after the accept edge.
    task automatic test_div_zero();
        int lat;
        sendPair(8'hAB, 8'h12, 1'b1);
        waitValid(lat);
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("[TB] FAIL dz_latency: got %0d extra edges want 0", lat);
        end
        checks++;
        if (outErr !== 1'b1 || quoBcd !== 12'h000 || remBcd !== 12'h000) begin
            errors++;
            $display("[TB] FAIL dz_value: err=%b q=%h r=%h want 1 000 000", outErr, quoBcd, remBcd);
        end
        handshake();
        divZero = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit quiet;
        sendPair(200, 50, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (inReady !== 1'b1 || outValid !== 1'b0 || quoBcd !== 12'h000 ||
            remBcd !== 12'h000 || outErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: rdy=%b vld=%b q=%h r=%h err=%b want 1 0 000 000 0",
                     inReady, outValid, quoBcd, remBcd, outErr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (outValid !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("[TB] FAIL mid_reset_no_pulse: out_valid=%b want 0", outValid);
        end
        sendPair(99, 3, 1'b0);
        waitValid(lat);
        checks++;
        if (lat !== 8 || quoBcd !== 12'h099 || remBcd !== 12'h003 || outErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_next: lat=%0d q=%h r=%h err=%b want 8 099 003 0",
                     lat, quoBcd, remBcd, outErr);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int qv[4] = '{255, 0, 128, 9};
        int rv[4] = '{254, 255, 99, 10};
        int acc[4];
        int k;
        int res;
        bit acceptNow;
        k   = 0;
        res = 0;
        @(negedge clk);
        quo      = 8'(qv[0]);
        rem      = 8'(rv[0]);
        inValid  = 1'b1;
        outReady = 1'b1;
        for (int cyc = 0; cyc < 80 && res < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (outValid === 1'b1) begin
                checks++;
                if (quoBcd !== toBcd(qv[res]) || remBcd !== toBcd(rv[res]) || outErr !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b2b_value[%0d]: q=%h r=%h err=%b want %h %h 0",
                             res, quoBcd, remBcd, outErr, toBcd(qv[res]), toBcd(rv[res]));
                end
                res++;
            end
            acceptNow = (inReady === 1'b1) && inValid;
            @(posedge clk);
            #1;
            if (acceptNow) begin
                acc[k] = cyc;
                k++;
                if (k < 4) begin
                    quo = 8'(qv[k]);
                    rem = 8'(rv[k]);
                end else begin
                    inValid = 1'b0;
                end
            end
        end
        inValid  = 1'b0;
        outReady = 1'b0;
        checks++;
        if (res !== 4 || k !== 4) begin
            errors++;
            $display("[TB] FAIL b2b_count: results=%0d accepts=%0d want 4 4", res, k);
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (acc[i] - acc[i-1] !== 10) begin
                    errors++;
                    $display("[TB] FAIL b2b_interval[%0d]: got %0d want 10", i, acc[i] - acc[i-1]);
                end
            end
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_exhaustive();
        int lat;
        for (int q = 0; q < 256; q++) begin
            sendPair(q, 255 - q, 1'b0);
            waitValid(lat);
            checks++;
            if (lat !== 8 || quoBcd !== toBcd(q) || remBcd !== toBcd(255 - q) || outErr !== 1'b0) begin
                errors++;
                $display("[TB] FAIL sweep[%0d]: lat=%0d q=%h r=%h want 8 %h %h",
                         q, lat, quoBcd, remBcd, toBcd(q), toBcd(255 - q));
            end
            handshake();
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b0;
        quo      = '0;
        rem      = '0;
        divZero  = 1'b0;
        #2;
        test_reset();
        test_max();
        test_small();
        test_hold();
        test_div_zero();
        test_reset_mid();
        test_back_to_back();
        test_exhaustive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
